// File: rtl/pl_tx_scheduler_pkg.sv
// Shared PD protocol-layer constants for the TX scheduler.
//   - state_t        : scheduler FSM encoding
//   - PKT_*          : packet-type codes presented to the PHY
//   - RES_*          : msg_result codes reported with msg_done
//   - GNT_*          : bit positions inside the one-hot grant vector {hr,gcrc,msg}
//   - select_requester : fixed-priority arbitration helper
package pl_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_PHY = 3'd2,
        ST_WAIT_CRC = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // Packet-type codes (SOP flavours and reset signalling)
    localparam logic [2:0] PKT_SOP         = 3'b000;
    localparam logic [2:0] PKT_SOP_P       = 3'b001;
    localparam logic [2:0] PKT_SOP_PP      = 3'b010;
    localparam logic [2:0] PKT_SOP_DBG_P   = 3'b011;
    localparam logic [2:0] PKT_SOP_DBG_PP  = 3'b100;
    localparam logic [2:0] PKT_HARD_RESET  = 3'b101;
    localparam logic [2:0] PKT_CABLE_RESET = 3'b110;

    // Message transaction outcome codes
    localparam logic [1:0] RES_OK         = 2'b00;
    localparam logic [1:0] RES_RETRY_FAIL = 2'b01;
    localparam logic [1:0] RES_ABORTED    = 2'b10;
    localparam logic [1:0] RES_DISCARDED  = 2'b11;

    // Grant vector bit positions
    localparam int GNT_HR   = 2;
    localparam int GNT_GCRC = 1;
    localparam int GNT_MSG  = 0;

    // Fixed priority hr > gcrc > msg. While a packet is being received only
    // the hard/cable reset requester may start a transmission.
    function automatic logic [2:0] select_requester(input logic hr,
                                                    input logic gcrc,
                                                    input logic msg,
                                                    input logic rx_busy);
        logic [2:0] sel;
        sel = 3'b000;
        if (hr)
            sel = 3'b100;
        else if (!rx_busy && gcrc)
            sel = 3'b010;
        else if (!rx_busy && msg)
            sel = 3'b001;
        return sel;
    endfunction

endpackage

// File: rtl/pl_tx_scheduler_crc_timer.sv
// pl_crc_receive_timer: CRCReceiveTimer for the TX scheduler.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the count from zero (dominates enable)
//   enable   : count one step per cycle while high
//   expire   : high while the count sits at TIMEOUT_CYC-1
// The count saturates at TIMEOUT_CYC-1 so it can never wrap back into range.
module pl_crc_receive_timer #(
    parameter int CNT_W       = 12,
    parameter int TIMEOUT_CYC = 2400
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && (count != LAST))
            count <= count + CNT_W'(1);
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/pl_tx_scheduler.sv
// pl_tx_scheduler: arbitrates the PHY TX path between the hard/cable-reset,
// GoodCRC and normal-message requesters, runs the CRCReceiveTimer and the
// retry loop for normal messages.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   hr_req/hr_type/hr_done    : hard/cable reset requester (level req, done pulse)
//   gcrc_req/gcrc_type/gcrc_done : GoodCRC requester
//   msg_req/msg_type/msg_done/msg_result : message requester and its outcome
//   grant                     : one-hot PHY owner {hr,gcrc,msg}
//   pl2phy_tx_packet_en/type  : start pulse and packet type to the PHY
//   phy2pl_tx_packet_done/result : PHY completion pulse and sent/discarded flag
//   rx_goodcrc                : GoodCRC with matching MessageID received
//   rx_busy                   : receive in progress, blocks non-reset starts
module pl_tx_scheduler
    import pl_tx_scheduler_pkg::*;
#(
    parameter int N_RETRY         = 3,
    parameter int CRC_TIMEOUT_CYC = 2400,
    parameter int CNT_W           = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hr_req,
    input  logic [2:0] hr_type,
    output logic       hr_done,
    input  logic       gcrc_req,
    input  logic [2:0] gcrc_type,
    output logic       gcrc_done,
    input  logic       msg_req,
    input  logic [2:0] msg_type,
    output logic       msg_done,
    output logic [1:0] msg_result,
    output logic [2:0] grant,
    output logic       pl2phy_tx_packet_en,
    output logic [2:0] pl2phy_tx_packet_type,
    input  logic       phy2pl_tx_packet_done,
    input  logic       phy2pl_tx_packet_result,
    input  logic       rx_goodcrc,
    input  logic       rx_busy
);

    localparam int RW = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);

    state_t      state;
    logic [RW-1:0] retry_cnt;
    logic [2:0]  sel;
    logic [2:0]  sel_type;
    logic        timer_clear;
    logic        timer_en;
    logic        timer_expire;

    assign sel = select_requester(hr_req, gcrc_req, msg_req, rx_busy);

    always_comb begin
        sel_type = 3'b000;
        case (sel)
            3'b100:  sel_type = hr_type;
            3'b010:  sel_type = gcrc_type;
            3'b001:  sel_type = msg_type;
            default: sel_type = 3'b000;
        endcase
    end

    // The timer restarts on the same edge that moves a sent message into
    // WAIT_CRC, so its first WAIT_CRC cycle reads zero.
    assign timer_clear = (state == ST_WAIT_PHY) && phy2pl_tx_packet_done &&
                         grant[GNT_MSG] && phy2pl_tx_packet_result;
    assign timer_en    = (state == ST_WAIT_CRC);

    pl_crc_receive_timer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (CRC_TIMEOUT_CYC)
    ) u_crc_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            grant                 <= 3'b000;
            hr_done               <= 1'b0;
            gcrc_done             <= 1'b0;
            msg_done              <= 1'b0;
            msg_result            <= RES_OK;
            pl2phy_tx_packet_en   <= 1'b0;
            pl2phy_tx_packet_type <= 3'b000;
            retry_cnt             <= '0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle.
            hr_done             <= 1'b0;
            gcrc_done           <= 1'b0;
            msg_done            <= 1'b0;
            pl2phy_tx_packet_en <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sel != 3'b000) begin
                        grant                 <= sel;
                        pl2phy_tx_packet_type <= sel_type;
                        state                 <= ST_START;
                    end
                end

                ST_START: begin
                    pl2phy_tx_packet_en <= 1'b1;
                    state               <= ST_WAIT_PHY;
                end

                // Grant and type stay frozen here; a late hr_req waits.
                ST_WAIT_PHY: begin
                    if (phy2pl_tx_packet_done) begin
                        if (grant[GNT_MSG]) begin
                            if (phy2pl_tx_packet_result) begin
                                state <= ST_WAIT_CRC;
                            end else begin
                                msg_done   <= 1'b1;
                                msg_result <= RES_DISCARDED;
                                state      <= ST_FINISH;
                            end
                        end else begin
                            hr_done   <= grant[GNT_HR];
                            gcrc_done <= grant[GNT_GCRC];
                            state     <= ST_FINISH;
                        end
                    end
                end

                // A matching GoodCRC outranks both an abort and a timeout
                // arriving in the same cycle: the message did get through.
                ST_WAIT_CRC: begin
                    if (rx_goodcrc) begin
                        msg_done   <= 1'b1;
                        msg_result <= RES_OK;
                        state      <= ST_FINISH;
                    end else if (hr_req) begin
                        msg_done   <= 1'b1;
                        msg_result <= RES_ABORTED;
                        state      <= ST_FINISH;
                    end else if (timer_expire) begin
                        if (retry_cnt < RW'(N_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_START;
                        end else begin
                            msg_done   <= 1'b1;
                            msg_result <= RES_RETRY_FAIL;
                            state      <= ST_FINISH;
                        end
                    end
                end

                ST_FINISH: begin
                    grant     <= 3'b000;
                    retry_cnt <= '0;
                    state     <= ST_IDLE;
                end

                default: begin
                    grant <= 3'b000;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
